// File: rtl/uart_rx_v2.sv
// Oversampling UART receiver with majority-vote bit sampling, parity/frame/overrun
// flags and a ready/valid output hold. Define UART_RX_BREAK_DET_EN for break detection.
module uart_rx_v2 #(
    parameter int OVERSAMPLE    = 16,
    parameter int MAX_DATA_BITS = 9,
    parameter int DIV_W         = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_en,
    input  logic [2:0]               data_bits,
    input  logic [1:0]               parity,
    input  logic                     stop_bit,
    input  logic [DIV_W-1:0]         rx_divisor,
    input  logic                     rx,
    input  logic                     rx_ready,
    input  logic                     ovr_clr,
    output logic [MAX_DATA_BITS-1:0] rx_data,
    output logic                     rx_valid,
    output logic                     err_frame,
    output logic                     err_parity,
    output logic                     err_overrun,
    output logic                     rx_break,
    output logic                     rx_idle
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_S0  = TW'(OVERSAMPLE/2 - 1);
    localparam logic [TW-1:0] T_S1  = TW'(OVERSAMPLE/2);
    localparam logic [TW-1:0] T_S2  = TW'(OVERSAMPLE/2 + 1);
    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    MAXB  = 4'(MAX_DATA_BITS);

`ifdef UART_RX_BREAK_DET_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`endif

    state_t                   state_q, state_d;
    logic                     rx_s1_q, rx_s2_q, rx_prev_q;
    logic [DIV_W-1:0]         presc_q, presc_d;
    logic [TW-1:0]            tick_q, tick_d;
    logic [1:0]               samp_q, samp_d;
    logic [3:0]               bit_idx_q, bit_idx_d;
    logic [3:0]               nbits_q, nbits_d;
    logic                     par_en_q, par_en_d;
    logic                     par_odd_q, par_odd_d;
    logic                     two_stop_q, two_stop_d;
    logic                     stop_idx_q, stop_idx_d;
    logic [MAX_DATA_BITS-1:0] shreg_q, shreg_d;
    logic                     par_acc_q, par_acc_d;
    logic                     perr_q, perr_d;
    logic                     ferr_q, ferr_d;
    logic                     zero_q, zero_d;
    logic [MAX_DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                     rx_valid_q, rx_valid_d;
    logic                     err_frame_q, err_frame_d;
    logic                     err_parity_q, err_parity_d;
    logic                     err_ovr_q, err_ovr_d;

    logic             rx_sync, fall, tick, maj, is_s2, end_bit;
    logic             done, brk, word_done, load;
    logic [DIV_W-1:0] div_eff;

    function automatic logic [3:0] dec_bits(input logic [2:0] code);
        logic [3:0] n;
        case (code)
            3'd0:    n = 4'd5;
            3'd1:    n = 4'd6;
            3'd2:    n = 4'd7;
            3'd4:    n = 4'd9;
            default: n = 4'd8;
        endcase
        if (n > MAXB) n = MAXB;
        return n;
    endfunction

    assign rx_sync = rx_s2_q;
    assign fall    = rx_prev_q & ~rx_s2_q;
    assign div_eff = (rx_divisor == '0) ? DIV_W'(1) : rx_divisor;
    // >= rather than == so a divisor lowered mid-count cannot stall the prescaler
    assign tick    = (presc_q >= div_eff - DIV_W'(1));
    assign maj     = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_sync) | (samp_q[0] & rx_sync);
    assign is_s2   = tick && (tick_q == T_S2);
    assign end_bit = tick && (tick_q == T_END);

    always_comb begin
        state_d      = state_q;
        presc_d      = tick ? '0 : presc_q + DIV_W'(1);
        tick_d       = tick_q;
        samp_d       = samp_q;
        bit_idx_d    = bit_idx_q;
        nbits_d      = nbits_q;
        par_en_d     = par_en_q;
        par_odd_d    = par_odd_q;
        two_stop_d   = two_stop_q;
        stop_idx_d   = stop_idx_q;
        shreg_d      = shreg_q;
        par_acc_d    = par_acc_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        zero_d       = zero_q;
        done         = 1'b0;
        brk          = 1'b0;

        if (state_q != S_IDLE && tick) tick_d = tick_q + 1'b1;
        if (tick && (tick_q == T_S0 || tick_q == T_S1)) samp_d = {samp_q[0], rx_sync};

        if (state_q != S_IDLE && !rx_en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_en && fall) begin
                        state_d    = S_START;
                        presc_d    = '0;
                        tick_d     = '0;
                        nbits_d    = dec_bits(data_bits);
                        par_en_d   = (parity == 2'b01) || (parity == 2'b10);
                        par_odd_d  = (parity == 2'b01);
                        two_stop_d = stop_bit;
                        bit_idx_d  = '0;
                        stop_idx_d = 1'b0;
                        shreg_d    = '0;
                        par_acc_d  = 1'b0;
                        perr_d     = 1'b0;
                        ferr_d     = 1'b0;
                        zero_d     = 1'b1;
                    end
                end
                S_START: begin
                    if (is_s2 && maj)  state_d = S_IDLE;
                    else if (end_bit)  state_d = S_DATA;
                end
                S_DATA: begin
                    if (is_s2) begin
                        shreg_d   = shreg_q | ({{(MAX_DATA_BITS-1){1'b0}}, maj} << bit_idx_q);
                        par_acc_d = par_acc_q ^ maj;
                        if (maj) zero_d = 1'b0;
                    end
                    if (end_bit) begin
                        if (bit_idx_q == nbits_q - 4'd1) state_d = par_en_q ? S_PARITY : S_STOP;
                        else                             bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
                S_PARITY: begin
                    if (is_s2) begin
                        perr_d = par_acc_q ^ maj ^ par_odd_q;
                        if (maj) zero_d = 1'b0;
                    end
                    if (end_bit) state_d = S_STOP;
                end
                S_STOP: begin
                    if (is_s2) begin
                        ferr_d = ferr_q | ~maj;
                        if (maj) zero_d = 1'b0;
                        if (stop_idx_q == two_stop_q) begin
                            done    = 1'b1;
                            state_d = S_IDLE;
`ifdef UART_RX_BREAK_DET_EN
                            if (zero_q && !maj) begin
                                brk     = 1'b1;
                                state_d = S_BREAK;
                            end
`endif
                        end
                    end else if (end_bit) begin
                        stop_idx_d = 1'b1;
                    end
                end
`ifdef UART_RX_BREAK_DET_EN
                S_BREAK: begin
                    if (rx_sync) state_d = S_IDLE;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output hold: a completed word only loads when the slot is free or being drained
    assign word_done = done & ~brk;
    assign load      = word_done & (~rx_valid_q | rx_ready);

    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        err_frame_d  = err_frame_q;
        err_parity_d = err_parity_q;
        err_ovr_d    = err_ovr_q;
        if (load) begin
            rx_data_d    = shreg_q;
            err_frame_d  = ferr_q | ~maj;
            err_parity_d = perr_q;
            rx_valid_d   = 1'b1;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d   = 1'b0;
        end
        if (word_done && rx_valid_q && !rx_ready) err_ovr_d = 1'b1;
        else if (ovr_clr)                         err_ovr_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            presc_q      <= '0;
            tick_q       <= '0;
            samp_q       <= '0;
            bit_idx_q    <= '0;
            nbits_q      <= '0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            two_stop_q   <= 1'b0;
            stop_idx_q   <= 1'b0;
            shreg_q      <= '0;
            par_acc_q    <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            zero_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            err_frame_q  <= 1'b0;
            err_parity_q <= 1'b0;
            err_ovr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_s1_q      <= rx;
            rx_s2_q      <= rx_s1_q;
            rx_prev_q    <= rx_s2_q;
            presc_q      <= presc_d;
            tick_q       <= tick_d;
            samp_q       <= samp_d;
            bit_idx_q    <= bit_idx_d;
            nbits_q      <= nbits_d;
            par_en_q     <= par_en_d;
            par_odd_q    <= par_odd_d;
            two_stop_q   <= two_stop_d;
            stop_idx_q   <= stop_idx_d;
            shreg_q      <= shreg_d;
            par_acc_q    <= par_acc_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            zero_q       <= zero_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            err_frame_q  <= err_frame_d;
            err_parity_q <= err_parity_d;
            err_ovr_q    <= err_ovr_d;
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    logic rx_break_q;
    always_ff @(posedge clk) begin
        if (rst) rx_break_q <= 1'b0;
        else     rx_break_q <= brk;
    end
    assign rx_break = rx_break_q;
`else
    assign rx_break = 1'b0;
`endif

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign err_frame   = err_frame_q;
    assign err_parity  = err_parity_q;
    assign err_overrun = err_ovr_q;
    assign rx_idle     = (state_q == S_IDLE);

endmodule

// File: tb/tb_uart_rx_v2.sv
// Bench for uart_rx_v2: frames are built from the serial protocol rules, expected
// words queued by a small model, and a monitor checks every loaded/held word.
module tb_uart_rx_v2;
    localparam int OS = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst, rx_en, stop_bit, rx, rx_ready, ovr_clr;
    logic [2:0]    data_bits;
    logic [1:0]    parity;
    logic [DW-1:0] rx_divisor;
    logic [8:0]    rx_data;
    logic          rx_valid, err_frame, err_parity, err_overrun, rx_break, rx_idle;

    always #5 clk = ~clk;

    uart_rx_v2 dut (
        .clk(clk), .rst(rst), .rx_en(rx_en), .data_bits(data_bits), .parity(parity),
        .stop_bit(stop_bit), .rx_divisor(rx_divisor), .rx(rx), .rx_ready(rx_ready),
        .ovr_clr(ovr_clr), .rx_data(rx_data), .rx_valid(rx_valid), .err_frame(err_frame),
        .err_parity(err_parity), .err_overrun(err_overrun), .rx_break(rx_break),
        .rx_idle(rx_idle)
    );

    typedef struct {
        logic [8:0] d;
        logic       fe;
        logic       pe;
    } word_t;

    word_t      exp_q[$];
    int         n_pass = 0, n_total = 0;
    int         brk_exp = 0, vcnt = 0, new_words = 0, bt = 64;
    bit         rand_ready = 0;
    logic [8:0] last_d = '0;
    logic       last_fe = 1'b0, last_pe = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int nb_of(input logic [2:0] c);
        return (c <= 3'd4) ? int'(c) + 5 : 8;
    endfunction

    // Reference: what the receiver must report for a frame, from protocol rules only
    task automatic model_push(input logic [8:0] dm, input logic pen, input logic pbit,
                              input bit perr, input logic [1:0] stops, input bit do_push);
        word_t w;
        bit    zero;
        w.d  = dm;
        w.fe = !stops[0] || (stop_bit && !stops[1]);
        w.pe = pen & perr;
        zero = (dm == 9'h0) && (!pen || !pbit) && !stops[0] && (!stop_bit || !stops[1]);
        if (!do_push) return;
`ifdef UART_RX_BREAK_DET_EN
        if (zero) begin
            brk_exp++;
            return;
        end
`else
        if (zero) w.fe = 1'b1;
`endif
        exp_q.push_back(w);
    endtask

    task automatic wait_bits(input int n);
        repeat (n * bt) @(negedge clk);
    endtask

    task automatic send(input logic [8:0] d, input bit perr, input logic [1:0] stops,
                        input bit do_push);
        int         nb;
        logic [8:0] dm, mask;
        logic       pen, pbit;
        nb   = nb_of(data_bits);
        mask = 9'((1 << nb) - 1);
        dm   = d & mask;
        pen  = (parity == 2'b01) || (parity == 2'b10);
        pbit = (^dm) ^ (parity == 2'b01) ^ perr;
        model_push(dm, pen, pbit, perr, stops, do_push);
        rx = 1'b0; wait_bits(1);
        for (int i = 0; i < nb; i++) begin
            rx = dm[i]; wait_bits(1);
        end
        if (pen) begin
            rx = pbit; wait_bits(1);
        end
        rx = stops[0]; wait_bits(1);
        if (stop_bit) begin
            rx = stops[1]; wait_bits(1);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1; wait_bits(n);
    endtask

    task automatic drain();
        int budget = 20000;
        while ((exp_q.size() != 0 || brk_exp != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("drain_words", exp_q.size(), 0);
        chk("drain_breaks", brk_exp, 0);
    endtask

    // Monitor: every newly loaded word is compared with the model; held words must not move
    initial begin
        logic       pv = 1'b0;
        logic [8:0] pd = '0;
        word_t      e;
        forever begin
            @(posedge clk); #1;
            if (rx_valid) vcnt++;
            if (rx_valid && (!pv || rx_ready)) begin
                new_words++;
                last_d = rx_data; last_fe = err_frame; last_pe = err_parity;
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_word: got %0h expected none (t=%0t)", rx_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_data", 32'(rx_data), 32'(e.d));
                    chk("word_frame_err", 32'(err_frame), 32'(e.fe));
                    chk("word_parity_err", 32'(err_parity), 32'(e.pe));
                end
            end else if (rx_valid && pv && !rx_ready) begin
                chk("held_stable", 32'(rx_data), 32'(pd));
            end
            if (rx_break) begin
                chk("break_expected", 32'(brk_exp > 0), 32'd1);
                if (brk_exp > 0) brk_exp--;
            end
            pv = rx_valid; pd = rx_data;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int         nw, div, gap;
        logic [8:0] d;
        bit         perr;
        logic [1:0] stops;

        rst = 1'b1; rx = 1'b1; rx_en = 1'b1; rx_ready = 1'b1; ovr_clr = 1'b0;
        data_bits = 3'd3; parity = 2'b00; stop_bit = 1'b0; rx_divisor = DW'(4); bt = OS * 4;
        repeat (3) @(negedge clk);
        chk("rst_idle", 32'(rx_idle), 32'd1);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_errs", {29'd0, err_frame, err_parity, err_overrun}, 32'd0);
        chk("rst_break", 32'(rx_break), 32'd0);
        rst = 1'b0;
        idle(2);

        // 8N1 0xA5, divisor 4
        vcnt = 0;
        send(9'h0A5, 0, 2'b11, 1); idle(2); drain();
        chk("a5_data", 32'(last_d), 32'h0A5);
        chk("a5_errs", {30'd0, last_fe, last_pe}, 32'd0);
        chk("a5_valid_cycles", vcnt, 1);

        // 9E1 0x1FF with parity bit 0 (even parity of nine ones needs 1)
        data_bits = 3'd4; parity = 2'b10;
        send(9'h1FF, 1, 2'b11, 1); idle(2); drain();
        chk("p9_data", 32'(last_d), 32'h1FF);
        chk("p9_perr", 32'(last_pe), 32'd1);

        // 8N2 0x3C, second stop bit low
        data_bits = 3'd3; parity = 2'b00; stop_bit = 1'b1;
        send(9'h03C, 0, 2'b01, 1); idle(2); drain();
        chk("n2_data", 32'(last_d), 32'h03C);
        chk("n2_ferr", 32'(last_fe), 32'd1);

        // Overrun: consumer stalled across two frames
        stop_bit = 1'b0; rx_ready = 1'b0;
        send(9'h011, 0, 2'b11, 1); idle(1);
        send(9'h022, 0, 2'b11, 0); idle(2); drain();
        chk("ovr_data", 32'(rx_data), 32'h011);
        chk("ovr_valid", 32'(rx_valid), 32'd1);
        chk("ovr_flag", 32'(err_overrun), 32'd1);
        ovr_clr = 1'b1; @(negedge clk); ovr_clr = 1'b0;
        chk("ovr_clear", 32'(err_overrun), 32'd0);
        rx_ready = 1'b1; @(negedge clk);
        chk("ovr_drained", 32'(rx_valid), 32'd0);

        // 20-clk glitch on a 64-clk bit
        nw = new_words;
        rx = 1'b0; repeat (20) @(negedge clk);
        rx = 1'b1; repeat (10) @(negedge clk);
        chk("glitch_in_start", 32'(rx_idle), 32'd0);
        idle(3);
        chk("glitch_idle", 32'(rx_idle), 32'd1);
        chk("glitch_no_word", new_words, nw);

        // Line low for 12 bit times, 8E1
        nw = new_words; parity = 2'b10;
        model_push(9'h0, 1'b1, 1'b0, 0, 2'b00, 1);
        rx = 1'b0; wait_bits(12); idle(2); drain();
`ifdef UART_RX_BREAK_DET_EN
        chk("break_no_word", new_words, nw);
`else
        chk("break_word_data", 32'(last_d), 32'h000);
        chk("break_word_ferr", 32'(last_fe), 32'd1);
`endif
        parity = 2'b00;

        // Reset mid-frame
        nw = new_words;
        rx = 1'b0; wait_bits(1); rx = 1'b1; wait_bits(1);
        chk("midframe_busy", 32'(rx_idle), 32'd0);
        rst = 1'b1; @(negedge clk);
        chk("midrst_idle", 32'(rx_idle), 32'd1);
        chk("midrst_valid", 32'(rx_valid), 32'd0);
        chk("midrst_data", 32'(rx_data), 32'd0);
        rst = 1'b0; idle(12);
        chk("midrst_no_word", new_words, nw);

        // Receiver disabled mid-frame
        rx = 1'b0; wait_bits(1); rx = 1'b1; wait_bits(2);
        rx_en = 1'b0; repeat (2) @(negedge clk);
        chk("abort_idle", 32'(rx_idle), 32'd1);
        rx = 1'b0; wait_bits(1); idle(2);
        rx_en = 1'b1; idle(2);
        chk("abort_no_word", new_words, nw);

        // Divisor 0 behaves as 1
        rx_divisor = '0; bt = OS;
        send(9'h05A, 0, 2'b11, 1); idle(2); drain();
        chk("div0_data", 32'(last_d), 32'h05A);

        // Randomised frames, random consumer back-pressure, back-to-back gaps
        rand_ready = 1;
        for (int k = 0; k < 40; k++) begin
            data_bits = 3'($urandom_range(0, 7));
            parity    = 2'($urandom_range(0, 3));
            stop_bit  = 1'($urandom_range(0, 1));
            div       = $urandom_range(1, 3);
            rx_divisor = DW'(div); bt = OS * div;
            d     = 9'($urandom);
            perr  = ($urandom_range(0, 4) == 0);
            stops = 2'b11;
            if ($urandom_range(0, 5) == 0) stops[$urandom_range(0, 1)] = 1'b0;
            if (k % 10 == 9) begin
                d = '0; stops = 2'b00;
            end
            send(d, perr, stops, 1);
            gap = $urandom_range(0, 2);
            if ((stop_bit ? stops[1] : stops[0]) == 1'b0 && gap == 0) gap = 1;
            idle(gap);
        end
        rand_ready = 0;
        @(negedge clk); rx_ready = 1'b1;
        idle(3); drain();
        chk("final_idle", 32'(rx_idle), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/uart_rx_v2.md
UART_RX_V2 -- requirements
Module: uart_rx_v2

Interface
REQ-001 SHALL provide parameter OVERSAMPLE, default 16, sample ticks per bit (power of two, 8..32).
REQ-002 SHALL provide parameter MAX_DATA_BITS, default 9, width of rx_data (5..9).
REQ-003 SHALL provide parameter DIV_W, default 16, width of rx_divisor.
REQ-004 SHALL provide ports (name direction width meaning), clock and reset first:
- clk  in  1  single system clock
- rst  in  1  synchronous, active-high reset
- rx_en  in  1  receiver enable
- data_bits  in  3  000=5, 001=6, 010=7, 011=8, 100=9 data bits; others=8
- parity  in  2  00 none, 01 odd, 10 even, 11 none
- stop_bit  in  1  0=one stop bit, 1=two stop bits
- rx_divisor  in  DIV_W  clk cycles per sample tick; 0 treated as 1
- rx  in  1  asynchronous serial line
- rx_ready  in  1  consumer accepts rx_data
- ovr_clr  in  1  clears err_overrun
- rx_data  out  MAX_DATA_BITS  received word, LSB first on line, right-aligned, unused upper bits 0
- rx_valid  out  1  rx_data/err_frame/err_parity valid
- err_frame  out  1  frame error of held word
- err_parity  out  1  parity error of held word
- err_overrun  out  1  sticky overrun flag
- rx_break  out  1  break detected (pulse)
- rx_idle  out  1  FSM in IDLE

Function
REQ-005 SHALL pass rx through a two-flop synchroniser (reset value 1) before any use.
REQ-006 SHALL generate one sample tick every rx_divisor clk cycles; prescaler and tick counter restart on start-edge detection.
REQ-007 SHALL implement states IDLE, START, DATA, PARITY, STOP, and (with macro) BREAK.
REQ-008 IDLE -> START on a synchronised falling edge while rx_en=1; data_bits, parity, stop_bit SHALL be latched at this transition and ignored until the next IDLE.
REQ-009 Each bit value SHALL be the majority of three samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1 of the bit.
REQ-010 START SHALL return to IDLE with no output if the start majority is 1 (glitch rejection); else -> DATA after OVERSAMPLE ticks.
REQ-011 DATA SHALL capture exactly the latched data-bit count, then -> PARITY if parity is 01/10, else -> STOP.
REQ-012 err_parity SHALL be 1 when the received parity bit mismatches odd (01) or even (10) parity over the data bits; 0 when parity is off.
REQ-013 STOP SHALL sample one or two stop bits; err_frame=1 if any stop bit is 0.
REQ-014 A frame SHALL complete at the third sample of the last stop bit; FSM returns to IDLE the next cycle, permitting back-to-back frames.
REQ-015 On completion with rx_valid=0 or rx_ready=1 in that cycle, rx_data and error flags SHALL load and rx_valid=1 the cycle after completion.
REQ-016 rx_valid SHALL remain 1 with stable rx_data until a cycle with rx_valid=1 and rx_ready=1; then clear unless a new word loads that same cycle.
REQ-017 On completion with rx_valid=1 and rx_ready=0, the new word SHALL be discarded, held word unchanged, err_overrun set.
REQ-018 err_overrun SHALL clear on ovr_clr=1; if set and clear coincide, set wins.
REQ-019 rx_en=0 mid-frame SHALL abort to IDLE next cycle with no output; held word unaffected.
REQ-020 rx_idle SHALL be 1 exactly when state is IDLE.

Reset
REQ-021 rst=1 at a clk edge SHALL force IDLE, rx_data=0, rx_valid=0, err_frame=0, err_parity=0, err_overrun=0, rx_break=0, rx_idle=1, synchroniser=1, counters=0, including mid-frame.

Configuration
REQ-022 Macro UART_RX_BREAK_DET_EN defined: a frame with all data, parity and stop samples 0 SHALL pulse rx_break for one cycle, load no word, and enter BREAK until synchronised rx=1, then IDLE.
REQ-023 Macro undefined: such a frame SHALL be treated as an ordinary word with err_frame=1; rx_break tied 0; no BREAK state.

Verification
REQ-024 Bench SHALL cover:
- OVERSAMPLE=16, rx_divisor=4, 8N1, byte 0xA5, rx_ready=1 -> rx_data=0x0A5, rx_valid one cycle, errors 0.
- 9 bits, even parity, word 0x1FF with parity bit 0 -> rx_data=0x1FF, err_parity=1.
- 8N2, 0x3C, second stop bit 0 -> rx_data=0x03C, err_frame=1.
- rx_ready=0, two 8N1 frames 0x11 then 0x22 -> rx_data stays 0x011, err_overrun=1; ovr_clr -> 0.
- 20-clk low glitch (bit = 64 clk) -> no rx_valid, FSM back to IDLE.
- Line low for 12 bit times, 8E1: with macro rx_break pulses, no rx_valid; without, rx_data=0x000, err_frame=1.
